// File: rtl/gb_pkg.sv
// gb_pkg: shared memory-map constants for the CPU-side memories.
package gb_pkg;
  localparam logic [7:0]  OPEN_BUS   = 8'hFF;
  localparam logic [15:0] HRAM_BASE  = 16'hFF80;
  localparam int          HRAM_DEPTH = 127;
  localparam int          HRAM_ASZ   = 7;
endpackage

// File: rtl/async_mem_array.sv
// async_mem_array: flop-based RAM with a synchronous write, a combinational read and an async clear.
module async_mem_array
  import gb_pkg::*;
#(
  parameter int asz   = HRAM_ASZ,
  parameter int depth = HRAM_DEPTH,
  parameter int dsz   = 8
) (
  input  logic           wr_clk,
  input  logic           reset,
  input  logic [asz-1:0] addr,
  input  logic [dsz-1:0] wr_data,
  input  logic           wr_cs,
  input  logic           rd_cs,
  output logic [dsz-1:0] rd_data
);
  logic [dsz-1:0] words [depth];
  logic           in_range;
  assign in_range = {1'b0, addr} < (asz+1)'(depth);
  for (genvar i = 0; i < depth; i++) begin : g_word
    logic [dsz-1:0] q;
    always_ff @(posedge wr_clk or posedge reset)
      if (reset) q <= '0;
      else if (wr_cs && addr == asz'(i)) q <= wr_data;
    assign words[i] = q;
  end
  // Deselected or unimplemented addresses float to the open-bus value.
  always_comb rd_data = (rd_cs && in_range) ? words[addr] : {dsz{1'b1}};
endmodule

// File: tb/tb_async_mem_array.sv
// tb_async_mem_array: directed checks of write, async read, open-bus and async clear behaviour.
module tb_async_mem_array;
  logic       wr_clk = 0;
  logic       reset;
  logic [6:0] addr;
  logic [7:0] wr_data;
  logic       wr_cs;
  logic       rd_cs;
  logic [7:0] rd_data;
  int checks = 0;
  int errors = 0;

  async_mem_array dut (
    .wr_clk(wr_clk), .reset(reset), .addr(addr), .wr_data(wr_data),
    .wr_cs(wr_cs), .rd_cs(rd_cs), .rd_data(rd_data)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    addr = a;
    wr_data = d;
    wr_cs = 1;
    @(posedge wr_clk);
    #1;
    wr_cs = 0;
  endtask

  task automatic chk(input string tag, input logic [6:0] a, input logic cs, input logic [7:0] exp);
    addr = a;
    rd_cs = cs;
    #1;
    checks++;
    assert (rd_data === exp) else begin
      errors++;
      $error("FAIL %s: addr=%0d rd_data=%h expected=%h", tag, a, rd_data, exp);
    end
  endtask

  initial begin
    reset = 1; addr = 0; wr_data = 0; wr_cs = 0; rd_cs = 0;
    #2;
    chk("reset_in_range", 7'd3, 1'b1, 8'h00);
    chk("reset_deselect", 7'd3, 1'b0, 8'hFF);
    chk("reset_oob", 7'd127, 1'b1, 8'hFF);
    @(posedge wr_clk);
    #1;
    reset = 0;
    for (int i = 0; i < 127; i++) wr(7'(i), 8'hA5);
    chk("fill_lo", 7'd0, 1'b1, 8'hA5);
    chk("fill_hi", 7'd126, 1'b1, 8'hA5);
    #1 reset = 1;
    #1 reset = 0;
    for (int i = 0; i < 127; i++) chk("async_clear", 7'(i), 1'b1, 8'h00);
    @(posedge wr_clk);
    #1;
    wr(7'd0, 8'h3C);
    wr(7'd126, 8'hC3);
    for (int i = 1; i < 126; i++) wr(7'(i), 8'(i));
    chk("rb_addr0", 7'd0, 1'b1, 8'h3C);
    chk("rb_addr126", 7'd126, 1'b1, 8'hC3);
    for (int i = 1; i < 126; i++) chk("readback", 7'(i), 1'b1, 8'(i));
    wr(7'd127, 8'h55);
    chk("oob_read", 7'd127, 1'b1, 8'hFF);
    chk("oob_no_alias0", 7'd0, 1'b1, 8'h3C);
    chk("oob_no_alias126", 7'd126, 1'b1, 8'hC3);
    chk("deselect_0", 7'd0, 1'b0, 8'hFF);
    chk("deselect_50", 7'd50, 1'b0, 8'hFF);
    addr = 7'd5;
    wr_cs = 0;
    for (int i = 0; i < 10; i++) begin
      wr_data = 8'(i * 37 + 1);
      @(posedge wr_clk);
      #1;
    end
    chk("no_wr_cs", 7'd5, 1'b1, 8'h05);
    wr(7'd9, 8'h11);
    addr = 7'd9; wr_data = 8'h22; wr_cs = 1;
    chk("rdw_before", 7'd9, 1'b1, 8'h11);
    @(posedge wr_clk);
    #1;
    wr_cs = 0;
    chk("rdw_after", 7'd9, 1'b1, 8'h22);
    wr(7'd1, 8'h01);
    chk("burst_w1", 7'd1, 1'b1, 8'h01);
    reset = 1;
    #1;
    chk("mid_reset_clear", 7'd1, 1'b1, 8'h00);
    addr = 7'd2; wr_data = 8'h02; wr_cs = 1;
    @(posedge wr_clk);
    #1;
    wr_cs = 0;
    chk("blocked_w_addr1", 7'd1, 1'b1, 8'h00);
    chk("blocked_w_addr2", 7'd2, 1'b1, 8'h00);
    reset = 0;
    chk("post_reset_addr1", 7'd1, 1'b1, 8'h00);
    chk("post_reset_addr2", 7'd2, 1'b1, 8'h00);
    wr(7'd2, 8'h77);
    chk("first_write_after_reset", 7'd2, 1'b1, 8'h77);
    chk("neighbour_untouched", 7'd3, 1'b1, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
